// File: rtl/tick_init_ctrl.sv
// tick_init_ctrl: debounced init/pause buttons driving an INIT/RUN/PAUSE FSM and a 1 Hz divider
// Ports:
//   fpga_clk      system clock, all logic on the rising edge
//   sys_rst_n     asynchronous active-low reset
//   btn_init      raw init button, asynchronous, active-high, bouncy
//   btn_pause     raw pause/resume button, asynchronous, active-high, bouncy
//   sys_init_ctrl high while the FSM is in INIT
//   clk_1Hz       divided 50% square wave
//   tick_1Hz      one-cycle pulse once per divider period
//   state         FSM state: 00=INIT, 01=RUN, 10=PAUSE
module tick_init_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       fpga_clk,
    input  logic       sys_rst_n,
    input  logic       btn_init,
    input  logic       btn_pause,
    output logic       sys_init_ctrl,
    output logic       clk_1Hz,
    output logic       tick_1Hz,
    output logic [1:0] state
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);
    localparam logic [DW-1:0] DB_MAX   = DW'(DB_CYCLES - 1);
    localparam logic [1:0] ST_INIT  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    // bit 0 carries init, bit 1 carries pause through the conditioning chain
    logic [1:0]    btn_raw, sync1, sync2, db, db_d, rise;
    logic [DW-1:0] db_cnt [2];
    logic [CW-1:0] count, count_nxt;
    logic [1:0]    state_nxt;
    logic          clk_nxt, tick_nxt;

    assign btn_raw       = {btn_pause, btn_init};
    assign sys_init_ctrl = state == ST_INIT;

    always_ff @(posedge fpga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            db_d  <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // init_rise overrides everything; in PAUSE the clock level is held rather than
    // recomputed, because the frozen count may already sit one step past the half point
    always_comb begin
        rise      = db & ~db_d;
        state_nxt = rise[0]            ? ST_INIT :
                    state == ST_INIT   ? (db[0] ? ST_INIT : ST_RUN) :
                    state == ST_RUN    ? (rise[1] ? ST_PAUSE : ST_RUN) :
                    state == ST_PAUSE  ? (rise[1] ? ST_RUN : ST_PAUSE) : ST_INIT;
        count_nxt = (rise[0] || state == ST_INIT) ? '0 :
                    state == ST_RUN ? (count == CNT_MAX ? '0 : count + CW'(1)) : count;
        clk_nxt   = (rise[0] || state == ST_INIT) ? 1'b0 :
                    state == ST_RUN ? (count >= CNT_HALF) : clk_1Hz;
        tick_nxt  = !rise[0] && state == ST_RUN && count == CNT_MAX;
    end

    always_ff @(posedge fpga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_INIT;
            count    <= '0;
            clk_1Hz  <= 1'b0;
            tick_1Hz <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            clk_1Hz  <= clk_nxt;
            tick_1Hz <= tick_nxt;
        end
    end
endmodule

// File: tb/tb_tick_init_ctrl.sv
// tb_tick_init_ctrl: self-checking bench for tick_init_ctrl with TICK_DIV=10, DB_CYCLES=4
module tb_tick_init_ctrl;
    localparam int TD = 10;
    localparam int DB = 4;

    logic       fpga_clk  = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       btn_init  = 1'b0;
    logic       btn_pause = 1'b0;
    logic       sys_init_ctrl, clk_1Hz, tick_1Hz;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    tick_init_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
        .fpga_clk     (fpga_clk),
        .sys_rst_n    (sys_rst_n),
        .btn_init     (btn_init),
        .btn_pause    (btn_pause),
        .sys_init_ctrl(sys_init_ctrl),
        .clk_1Hz      (clk_1Hz),
        .tick_1Hz     (tick_1Hz),
        .state        (state)
    );

    always #5 fpga_clk = ~fpga_clk;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a button is accepted once the raw samples seen two edges ago and the
    // DB-1 before them all agree on a value other than the accepted one.
    // The time base is the number of RUN edges since the last INIT, taken mod TD.
    int          m_state = 0;
    int          m_p     = 0;
    int          cyc     = 0;
    bit          m_clk   = 0;
    bit          m_tick  = 0;
    bit [1:0]    m_db    = '0;
    bit [1:0]    m_db_d  = '0;
    bit [1:0]    m_rise;
    bit [31:0]   h_i     = '0;
    bit [31:0]   h_p     = '0;

    function automatic bit settle(bit [31:0] h, bit cur);
        bit v;
        v = h[2];
        for (int j = 2; j <= DB + 1; j++) if (h[j] != v) return cur;
        return v;
    endfunction

    initial forever begin
        @(posedge fpga_clk or negedge sys_rst_n);
        if (!sys_rst_n) begin
            m_state = 0; m_p = 0; cyc = 0; m_clk = 0; m_tick = 0;
            m_db = '0; m_db_d = '0; h_i = '0; h_p = '0;
        end else begin
            cyc++;
            m_rise = m_db & ~m_db_d;
            if (m_rise[0]) begin
                m_state = 0; m_p = 0; m_clk = 0; m_tick = 0;
            end else if (m_state == 0) begin
                m_p = 0; m_clk = 0; m_tick = 0;
                if (!m_db[0]) m_state = 1;
            end else if (m_state == 1) begin
                m_tick = (m_p % TD) == TD - 1;
                m_clk  = (m_p % TD) >= TD / 2;
                m_p++;
                if (m_rise[1]) m_state = 2;
            end else begin
                m_tick = 0;
                if (m_rise[1]) m_state = 1;
            end
            h_i    = {h_i[30:0], btn_init};
            h_p    = {h_p[30:0], btn_pause};
            m_db_d = m_db;
            m_db   = {settle(h_p, m_db[1]), settle(h_i, m_db[0])};
        end
    end

    int last_tick = 0;
    int gap       = 0;

    initial forever begin
        @(negedge fpga_clk);
        chk("state", int'(state), m_state);
        chk("init_ctrl", int'(sys_init_ctrl), int'(m_state == 0));
        chk("clk_1Hz", int'(clk_1Hz), int'(m_clk));
        chk("tick_1Hz", int'(tick_1Hz), int'(m_tick));
        if (!sys_rst_n) begin
            last_tick = 0;
        end else if (tick_1Hz) begin
            gap       = cyc - last_tick;
            last_tick = cyc;
        end
    end

    task automatic clocks(int n);
        repeat (n) @(negedge fpga_clk);
    endtask

    task automatic wait_tick(int lim);
        int k = 0;
        do begin
            @(negedge fpga_clk);
            k++;
        end while (!tick_1Hz && k < lim);
        if (!tick_1Hz) chk("tick_timeout", 0, 1);
        #1;
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_init"}, int'(sys_init_ctrl), 1);
        chk({tag, "_clk"}, int'(clk_1Hz), 0);
        chk({tag, "_tick"}, int'(tick_1Hz), 0);
    endtask

    task automatic startup(string tag);
        sys_rst_n = 1'b1;
        clocks(1);
        chk({tag, "_entry_state"}, int'(state), 1);
        chk({tag, "_entry_init"}, int'(sys_init_ctrl), 0);
        wait_tick(30);
        chk({tag, "_first_tick"}, last_tick, 11);
    endtask

    initial begin
        int hi;
        int e;
        int k;
        clocks(3);
        check_reset_vals("rst");
        startup("boot");
        wait_tick(30);
        chk("second_tick", last_tick, 21);
        chk("tick_period", gap, 10);
        hi = 0;
        repeat (TD) begin
            @(negedge fpga_clk);
            hi += int'(clk_1Hz);
        end
        chk("clk_high_cycles", hi, TD / 2);

        for (int w = 1; w <= 3; w++) begin
            @(negedge fpga_clk);
            btn_init = 1'b1;
            clocks(w);
            btn_init = 1'b0;
            clocks(10);
            chk("glitch_state", int'(state), 1);
        end
        wait_tick(30);
        chk("glitch_period", gap, 10);

        @(negedge fpga_clk);
        btn_init = 1'b1;
        clocks(6);
        chk("init_lat6", int'(state), 1);
        clocks(1);
        chk("init_lat7_state", int'(state), 0);
        chk("init_lat7_ctrl", int'(sys_init_ctrl), 1);
        chk("init_lat7_clk", int'(clk_1Hz), 0);
        clocks(13);
        btn_init = 1'b0;
        clocks(6);
        chk("rel_lat6", int'(state), 0);
        clocks(1);
        chk("rel_lat7", int'(state), 1);
        e = cyc;
        wait_tick(30);
        chk("init_restart", last_tick - e, 10);

        k = 0;
        do begin
            @(negedge fpga_clk);
            k++;
        end while (!(m_state == 1 && m_p % TD == 3) && k < 40);
        chk("count3_found", int'(k < 40), 1);
        btn_pause = 1'b1;
        clocks(7);
        chk("pause_entry", int'(state), 2);
        clocks(3);
        btn_pause = 1'b0;
        clocks(10);
        chk("paused_hold", int'(state), 2);
        clocks(10);
        btn_pause = 1'b1;
        clocks(10);
        btn_pause = 1'b0;
        chk("resumed", int'(state), 1);
        wait_tick(50);
        chk("pause_gap", gap, 40);

        @(negedge fpga_clk);
        btn_init  = 1'b1;
        btn_pause = 1'b1;
        clocks(7);
        chk("simul_init_wins", int'(state), 0);
        clocks(5);
        btn_init  = 1'b0;
        btn_pause = 1'b0;
        clocks(8);
        chk("simul_recover", int'(state), 1);

        clocks(13);
        @(posedge fpga_clk);
        #2 sys_rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        clocks(2);
        startup("reboot");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
